ram_console: RTL
================

RAM_CONSOLE -- requirements
Module: ram_console

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-low reset; all state SHALL update only on the rising edge of clk.
REQ-002 Parameter DATA_W, default 4: width of the memory word and of the entry value (4..8).
REQ-003 Parameter ADDR_W, default 4: memory address width; depth is 2**ADDR_W.
REQ-004 Parameter DEB_CYC, default 262144: number of clk cycles a key level must hold before it is accepted.
REQ-005 Parameter SCAN_DIV, default 12000000: clk cycles per address step in SCAN mode.
REQ-006 Port clk, input, 1: system clock (12 MHz on board).
REQ-007 Port rst, input, 1: synchronous active-low reset.
REQ-008 Port key_inc, input, 1: active-low button that increments the entry value.
REQ-009 Port key_write, input, 1: active-low button that writes the entry value in EDIT mode.
REQ-010 Port key_mode, input, 1: active-low button that cycles the mode.
REQ-011 Port addr_sw, input, ADDR_W: address switches used in EDIT mode.
REQ-012 Port segment_led_1, output, 9: digit showing the low nibble of the entry value; bits MSB..LSB are SEG,DP,G,F,E,D,C,B,A.
REQ-013 Port segment_led_2, output, 9: digit showing the low nibble of the memory read data, same encoding.
REQ-014 Port cur_addr, output, ADDR_W: address currently applied to the memory.
REQ-015 Port mode_led, output, 2: current mode (00 EDIT, 01 SCAN, 10 CLEAR).
REQ-016 Port busy, output, 1: high while CLEAR is in progress.

Function
REQ-017 Each key SHALL be filtered: after the level is stable for DEB_CYC cycles, a 1→0 transition of the accepted level SHALL produce exactly one single-cycle pulse; bounces shorter than DEB_CYC SHALL produce no pulse.
REQ-018 An inc pulse SHALL set entry = entry + 1, wrapping modulo 2**DATA_W; inc is accepted in every mode.
REQ-019 The memory SHALL be 2**ADDR_W × DATA_W with a synchronous write and a registered read of one cycle latency; segment_led_2 SHALL reflect mem[cur_addr] one cycle after cur_addr or the contents change.
REQ-020 EDIT: cur_addr = addr_sw; a write pulse SHALL store entry at addr_sw on the same edge.
REQ-021 SCAN: cur_addr SHALL advance by 1 every SCAN_DIV cycles, wrapping from 2**ADDR_W-1 to 0; write pulses SHALL be ignored.
REQ-022 CLEAR: one word per cycle SHALL be written with 0 at cur_addr = 0..2**ADDR_W-1; busy SHALL be high for exactly 2**ADDR_W cycles, then the mode SHALL return to EDIT with busy low.
REQ-023 A mode pulse SHALL step EDIT→SCAN→CLEAR; a mode pulse during CLEAR (busy=1) SHALL be ignored.
REQ-024 Entering SCAN or CLEAR SHALL reset the scan divider and start cur_addr at 0.
REQ-025 If mode and write pulses occur in the same cycle in EDIT, the write SHALL complete and the mode SHALL change on that same edge.
REQ-026 The segment table SHALL be 0-9 = 03F,006,05B,04F,066,06D,07D,007,07F,06F and A-F = 077,07C,039,05E,079,071 (hex, 9-bit).

Reset
REQ-027 While rst=0: entry=0, mode=EDIT, busy=0, scan divider=0, and the accepted level of every key held at 1 with no pulses emitted.
REQ-028 Reset SHALL NOT clear memory contents; reset asserted during CLEAR SHALL abort the sweep, leaving addresses not yet cleared unchanged.
REQ-029 After reset: mode_led=00, segment_led_1=03F, cur_addr=addr_sw.

Structure
REQ-030 Package ram_console_pkg SHALL hold the mode encoding constants and the 16-entry segment table.
REQ-031 Key filtering SHALL be implemented in one sub-module, key_filter (parameter N keys, DEB_CYC), instantiated once for all three keys.

Verification (DEB_CYC=4, SCAN_DIV=8, DATA_W=4, ADDR_W=4)
REQ-032 Press inc 3 times, addr_sw=5, press write → mem[5]=3; segment_led_2=04F one cycle later.
REQ-033 Press inc 17 times from reset → entry wraps to 1; segment_led_1=006.
REQ-034 Key bounce 1-0-1-0 in 2-cycle intervals, then held low → exactly one inc pulse.
REQ-035 Mode pressed twice → busy high for 16 cycles, all words read 0, mode_led returns to 00; a mode press during busy has no effect.
REQ-036 SCAN with mem[0]=A, mem[1]=7 → cur_addr steps every 8 cycles; segment_led_2 shows 077 then 007; wraps from 15 to 0.
REQ-037 Reset asserted after 5 CLEAR cycles → mem[5..15] retain prior values; mode=EDIT, entry=0.

Source files
------------

// File: rtl/ram_console_pkg.sv
// ram_console_pkg
//   Shared definitions for the RAM console: the mode encoding shown on
//   mode_led and the 16-entry seven-segment table.
//   Segment words are 9 bits, MSB..LSB = SEG,DP,G,F,E,D,C,B,A.
package ram_console_pkg;

   typedef enum logic [1:0] {
      MODE_EDIT  = 2'b00,
      MODE_SCAN  = 2'b01,
      MODE_CLEAR = 2'b10
   } mode_e;

   // Packed array: the last listed element is index 0, so digits run F..0.
   localparam logic [15:0][8:0] SEG_TABLE = {
      9'h071, 9'h079, 9'h05E, 9'h039, 9'h07C, 9'h077,
      9'h06F, 9'h07F, 9'h007, 9'h07D, 9'h06D, 9'h066,
      9'h04F, 9'h05B, 9'h006, 9'h03F
   };

   function automatic logic [8:0] seg_encode(input logic [3:0] nib);
      return SEG_TABLE[nib];
   endfunction

endpackage

// File: rtl/ram_console_key_filter.sv
// key_filter
//   Debounces N active-low keys. Each raw key is brought through a two-stage
//   synchronizer; a new level is accepted only after it has differed from the
//   accepted level for DEB_CYC consecutive cycles. A 1->0 change of the
//   accepted level emits one single-cycle pulse.
// Ports
//   clk      system clock
//   rst      synchronous active-low reset (accepted levels forced to 1)
//   keys_i   raw key levels, active low
//   press_o  one-cycle press pulse per key
module key_filter #(
   parameter int N       = 3,
   parameter int DEB_CYC = 262144
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [N-1:0] keys_i,
   output logic [N-1:0] press_o
);

   localparam int CNT_W = (DEB_CYC > 1) ? $clog2(DEB_CYC) : 1;

   for (genvar gi = 0; gi < N; gi++) begin : g_key
      logic             sync1_q;
      logic             sync2_q;
      logic             level_q;
      logic             press_q;
      logic [CNT_W-1:0] cnt_q;

      always_ff @(posedge clk) begin
         if (!rst) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            level_q <= 1'b1;
            press_q <= 1'b0;
            cnt_q   <= '0;
         end else begin
            sync1_q <= keys_i[gi];
            sync2_q <= sync1_q;
            press_q <= 1'b0;
            if (sync2_q == level_q) begin
               // Any return to the accepted level restarts the hold window.
               cnt_q <= '0;
            end else if (cnt_q == CNT_W'(DEB_CYC - 1)) begin
               level_q <= sync2_q;
               cnt_q   <= '0;
               press_q <= ~sync2_q;
            end else begin
               cnt_q <= cnt_q + 1'b1;
            end
         end
      end

      assign press_o[gi] = press_q;
   end

endmodule

// File: rtl/ram_console.sv
// ram_console
//   Small memory console: an entry value is incremented with a key and
//   written into a 2**ADDR_W x DATA_W RAM in EDIT mode; SCAN mode steps the
//   address periodically; CLEAR mode zeroes the RAM one word per cycle.
// Ports
//   clk            system clock
//   rst            synchronous active-low reset (RAM contents are kept)
//   key_inc        active-low key: entry + 1
//   key_write      active-low key: write entry at addr_sw (EDIT only)
//   key_mode       active-low key: EDIT -> SCAN -> CLEAR
//   addr_sw        address switches used in EDIT
//   segment_led_1  digit of entry low nibble
//   segment_led_2  digit of RAM read data low nibble
//   cur_addr       address applied to the RAM
//   mode_led       current mode encoding
//   busy           high while CLEAR sweeps the RAM
module ram_console
   import ram_console_pkg::*;
#(
   parameter int DATA_W   = 4,
   parameter int ADDR_W   = 4,
   parameter int DEB_CYC  = 262144,
   parameter int SCAN_DIV = 12000000
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              key_inc,
   input  logic              key_write,
   input  logic              key_mode,
   input  logic [ADDR_W-1:0] addr_sw,
   output logic [8:0]        segment_led_1,
   output logic [8:0]        segment_led_2,
   output logic [ADDR_W-1:0] cur_addr,
   output logic [1:0]        mode_led,
   output logic              busy
);

   localparam int DEPTH = 2 ** ADDR_W;
   localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

   logic [2:0] press;
   logic       inc_p, write_p, mode_p;

   key_filter #(
      .N       (3),
      .DEB_CYC (DEB_CYC)
   ) u_key_filter (
      .clk     (clk),
      .rst     (rst),
      .keys_i  ({key_mode, key_write, key_inc}),
      .press_o (press)
   );

   assign inc_p   = press[0];
   assign write_p = press[1];
   assign mode_p  = press[2];

   mode_e             mode_q, mode_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DIV_W-1:0]  div_q, div_d;
   logic [DATA_W-1:0] entry_q, entry_d;

   logic              mem_we;
   logic [ADDR_W-1:0] mem_waddr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [DATA_W-1:0] rd_q;

   always_ff @(posedge clk) begin
      if (!rst) begin
         mode_q  <= MODE_EDIT;
         addr_q  <= '0;
         div_q   <= '0;
         entry_q <= '0;
      end else begin
         mode_q  <= mode_d;
         addr_q  <= addr_d;
         div_q   <= div_d;
         entry_q <= entry_d;
      end
   end

   always_comb begin
      mode_d    = mode_q;
      addr_d    = addr_q;
      div_d     = div_q;
      entry_d   = inc_p ? entry_q + DATA_W'(1) : entry_q;
      mem_we    = 1'b0;
      mem_waddr = addr_sw;
      mem_wdata = entry_q;
      case (mode_q)
         MODE_EDIT: begin
            // Write uses the current mode, so a simultaneous mode press
            // still lets the write land on this edge.
            mem_we = write_p;
            if (mode_p) begin
               mode_d = MODE_SCAN;
               addr_d = '0;
               div_d  = '0;
            end
         end
         MODE_SCAN: begin
            if (mode_p) begin
               mode_d = MODE_CLEAR;
               addr_d = '0;
               div_d  = '0;
            end else if (div_q == DIV_W'(SCAN_DIV - 1)) begin
               div_d  = '0;
               addr_d = addr_q + 1'b1;
            end else begin
               div_d = div_q + 1'b1;
            end
         end
         MODE_CLEAR: begin
            // Gated by rst so an abort never clears one extra word.
            mem_we    = rst;
            mem_waddr = addr_q;
            mem_wdata = '0;
            addr_d    = addr_q + 1'b1;
            if (addr_q == ADDR_W'(DEPTH - 1)) begin
               mode_d = MODE_EDIT;
            end
         end
         default: mode_d = MODE_EDIT;
      endcase
   end

   assign cur_addr = (mode_q == MODE_EDIT) ? addr_sw : addr_q;

   // Block RAM: synchronous write, registered read, no reset.
   always_ff @(posedge clk) begin
      if (mem_we) begin
         mem_q[mem_waddr] <= mem_wdata;
      end
      rd_q <= mem_q[cur_addr];
   end

   assign segment_led_1 = seg_encode(entry_q[3:0]);
   assign segment_led_2 = seg_encode(rd_q[3:0]);
   assign mode_led      = mode_q;
   assign busy          = (mode_q == MODE_CLEAR);

endmodule
